// File: rtl/gnr_ctrl_pkg.sv
// Shared types and default sizing for the GNR attractor sequencer.
// Imported by the controller, its comparator and the job interface.
package gnr_ctrl_pkg;

  localparam int unsigned DefaultN        = 188;
  localparam int unsigned DefaultCntW     = 32;
  localparam int unsigned DefaultMaxSteps = 2 ** 20;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StPeriod,
    StDone
  } gnr_state_e;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Host-side job interface of the attractor sequencer: request, busy/done handshake and results.
// The host drives through master; the controller implements slave.
interface gnr_attractor_ctrl_if
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned CNT_W = DefaultCntW
);

  logic             start;
  logic [N-1:0]     init_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] meet_steps;
  logic [CNT_W-1:0] period;
  logic [N-1:0]     attractor;

  modport master (
    output start,
    output init_in,
    input  busy,
    input  done,
    input  timeout,
    input  meet_steps,
    input  period,
    input  attractor
  );

  modport slave (
    input  start,
    input  init_in,
    output busy,
    output done,
    output timeout,
    output meet_steps,
    output period,
    output attractor
  );

endinterface

// File: rtl/gnr_vec_cmp.sv
// Combinational N-bit equality of two state vectors.
// Per-bit differences are OR-reduced through a binary tree stored heap-style.
module gnr_vec_cmp
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  localparam int unsigned Levels = $clog2(N);
  localparam int unsigned Leaves = 1 << Levels;

  logic [N-1:0]          diff;
  // Node i has children 2i+1 and 2i+2; leaves start at Leaves-1.
  logic [2*Leaves-2:0]   tree;

  assign diff = a ^ b;

  for (genvar j = 0; j < Leaves; j++) begin : g_leaf
    if (j < N) begin : g_used
      assign tree[Leaves-1+j] = diff[j];
    end else begin : g_pad
      assign tree[Leaves-1+j] = 1'b0;
    end
  end

  for (genvar i = 0; i < Leaves - 1; i++) begin : g_node
    assign tree[i] = tree[2*i+1] | tree[2*i+2];
  end

  assign eq = ~tree[0];

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sequencer for the GNR node array: tortoise/hare meet detection followed by
// attractor period measurement, with a step limit per phase.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N         = DefaultN,
  parameter int unsigned CNT_W     = DefaultCntW,
  parameter int unsigned MAX_STEPS = DefaultMaxSteps
) (
  input  logic                 clk,
  input  logic                 rst,
  gnr_attractor_ctrl_if.slave  job,
  input  logic [N-1:0]         s0_vec,
  input  logic [N-1:0]         s1_vec,
  output logic                 reset_nos,
  output logic [N-1:0]         init_state,
  output logic                 start_s0,
  output logic                 start_s1
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);

  gnr_state_e       state_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] meet_q;
  logic [CNT_W-1:0] period_q;
  logic [N-1:0]     attr_q;
  logic [N-1:0]     init_q;
  logic             timeout_q;
  logic             busy_q;
  logic             done_q;
  logic             reset_nos_q;

  logic vec_eq;
  logic run_hit;
  logic per_hit;

  gnr_vec_cmp #(
    .N (N)
  ) u_cmp (
    .a  (s0_vec),
    .b  (s1_vec),
    .eq (vec_eq)
  );

  // steps==1 always compares equal (both copies advanced once), so it is not a meet.
  assign run_hit = (state_q == StRun) && vec_eq && (steps_q >= CntTwo);
  assign per_hit = (state_q == StPeriod) && vec_eq && (p_q != '0);

  always_comb begin
    start_s0 = 1'b0;
    start_s1 = 1'b0;
    unique case (state_q)
      StRun: begin
        start_s0 = ~run_hit;
        start_s1 = ~run_hit;
      end
      StPeriod: start_s1 = ~per_hit;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      steps_q     <= '0;
      p_q         <= '0;
      meet_q      <= '0;
      period_q    <= '0;
      attr_q      <= '0;
      init_q      <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reset_nos_q <= 1'b0;
    end else begin
      reset_nos_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (job.start) begin
            init_q      <= job.init_in;
            steps_q     <= '0;
            p_q         <= '0;
            meet_q      <= '0;
            period_q    <= '0;
            attr_q      <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            reset_nos_q <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          steps_q <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (run_hit) begin
            meet_q  <= steps_q;
            p_q     <= '0;
            state_q <= StPeriod;
          end else if (steps_q == MaxCnt) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            steps_q <= steps_q + CntOne;
          end
        end
        StPeriod: begin
          if (per_hit) begin
            period_q <= p_q;
            attr_q   <= s0_vec;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (p_q == MaxCnt) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            p_q <= p_q + CntOne;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reset_nos      = reset_nos_q;
  assign init_state     = init_q;
  assign job.busy       = busy_q;
  assign job.done       = done_q;
  assign job.timeout    = timeout_q;
  assign job.meet_steps = meet_q;
  assign job.period     = period_q;
  assign job.attractor  = attr_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (default and 20-step limit) driving
// 4-node behavioural networks, with a result scoreboard and reset/protocol sequences.
module tb_gnr_attractor_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 24;

  typedef struct {
    bit             sel;
    int             mode;
    logic [N-1:0]   init;
    logic [CW-1:0]  meet;
    logic [CW-1:0]  per;
    logic           to;
    logic [N-1:0]   attr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gnr_attractor_ctrl_if #(.N(N), .CNT_W(CW)) job_a ();
  gnr_attractor_ctrl_if #(.N(N), .CNT_W(CW)) job_b ();

  logic [N-1:0] s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;
  logic         pass_a = 1'b0, pass_b = 1'b0;
  logic [N-1:0] init_state_a, init_state_b;
  logic         reset_nos_a, reset_nos_b, start_s0_a, start_s0_b, start_s1_a, start_s1_b;

  bit           cur_sel;
  int           mode;
  logic         start_drv;
  logic [N-1:0] init_drv;

  assign job_a.start   = start_drv && !cur_sel;
  assign job_b.start   = start_drv && cur_sel;
  assign job_a.init_in = init_drv;
  assign job_b.init_in = init_drv;

  gnr_attractor_ctrl #(.N(N), .CNT_W(CW)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .job        (job_a.slave),
    .s0_vec     (s0_a),
    .s1_vec     (s1_a),
    .reset_nos  (reset_nos_a),
    .init_state (init_state_a),
    .start_s0   (start_s0_a),
    .start_s1   (start_s1_a)
  );

  gnr_attractor_ctrl #(.N(N), .CNT_W(CW), .MAX_STEPS(20)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .job        (job_b.slave),
    .s0_vec     (s0_b),
    .s1_vec     (s1_b),
    .reset_nos  (reset_nos_b),
    .init_state (init_state_b),
    .start_s0   (start_s0_b),
    .start_s1   (start_s1_b)
  );

  function automatic logic [N-1:0] net_f(input int m, input logic [N-1:0] x);
    case (m)
      0:       return x;
      1:       return {x[N-2:0], x[N-1]};
      default: return x + 4'd1;
    endcase
  endfunction

  // Node array model: load sets pass, tortoise moves on every other s0 pulse starting with the first.
  always @(posedge clk) begin
    if (reset_nos_a) begin
      s0_a <= init_state_a; s1_a <= init_state_a; pass_a <= 1'b1;
    end else begin
      if (start_s0_a) begin
        if (pass_a) s0_a <= net_f(mode, s0_a);
        pass_a <= ~pass_a;
      end
      if (start_s1_a) s1_a <= net_f(mode, s1_a);
    end
    if (reset_nos_b) begin
      s0_b <= init_state_b; s1_b <= init_state_b; pass_b <= 1'b1;
    end else begin
      if (start_s0_b) begin
        if (pass_b) s0_b <= net_f(mode, s0_b);
        pass_b <= ~pass_b;
      end
      if (start_s1_b) s1_b <= net_f(mode, s1_b);
    end
  end

  logic          busy_m, done_m, to_m, reset_nos_m, start_s0_m, start_s1_m;
  logic [N-1:0]  init_state_m, attr_m;
  logic [CW-1:0] meet_m, per_m;

  always_comb begin
    if (cur_sel) begin
      busy_m = job_b.busy; done_m = job_b.done; to_m = job_b.timeout;
      meet_m = job_b.meet_steps; per_m = job_b.period; attr_m = job_b.attractor;
      reset_nos_m = reset_nos_b; start_s0_m = start_s0_b; start_s1_m = start_s1_b;
      init_state_m = init_state_b;
    end else begin
      busy_m = job_a.busy; done_m = job_a.done; to_m = job_a.timeout;
      meet_m = job_a.meet_steps; per_m = job_a.period; attr_m = job_a.attractor;
      reset_nos_m = reset_nos_a; start_s0_m = start_s0_a; start_s1_m = start_s1_a;
      init_state_m = init_state_a;
    end
  end

  int   total, bad, viol;
  vec_t exp_q[$];
  vec_t vecs[7];

  always @(negedge clk) begin
    if ((reset_nos_a && (start_s0_a || start_s1_a)) ||
        (reset_nos_b && (start_s0_b || start_s1_b))) viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {busy_m, done_m, to_m, reset_nos_m, start_s0_m, start_s1_m}, '0);
    check({tag, "_vec"}, {init_state_m, attr_m}, '0);
    check({tag, "_meet"}, meet_m, '0);
    check({tag, "_per"}, per_m, '0);
  endtask

  task automatic run_job(input vec_t v, input bit inject);
    vec_t e;
    bit   seen;
    cur_sel   = v.sel;
    mode      = v.mode;
    init_drv  = v.init;
    start_drv = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start_drv = 1'b0;
    check("load_strobe", reset_nos_m, 1);
    check("load_init", init_state_m, v.init);
    @(posedge clk); #1;
    check("load_once", reset_nos_m, 0);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (inject && c == 4) begin
        init_drv  = 4'b1111;
        start_drv = 1'b1;
      end else begin
        start_drv = 1'b0;
      end
      @(posedge clk); #1;
      seen = done_m;
    end
    start_drv = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_wait: no done within 300 cycles, required one done pulse");
    end else begin
      check("busy_at_done", busy_m, 1);
      check("meet_steps", meet_m, e.meet);
      check("period", per_m, e.per);
      check("timeout", to_m, e.to);
      check("attractor", attr_m, e.attr);
      @(posedge clk); #1;
      check("done_once", done_m, 0);
      check("busy_drop", busy_m, 0);
      check("results_hold", per_m, e.per);
    end
  endtask

  initial begin
    bit found;
    bit done_seen;
    total = 0; bad = 0; viol = 0;
    rst = 1'b1; start_drv = 1'b0; init_drv = '0; cur_sel = 1'b0; mode = 0;

    //          sel   mode init     meet   per    to    attr
    vecs[0] = '{1'b0, 0, 4'b1010, 24'd2,  24'd1,  1'b0, 4'b1010};
    vecs[1] = '{1'b0, 1, 4'b0001, 24'd8,  24'd4,  1'b0, 4'b0001};
    vecs[2] = '{1'b0, 2, 4'b0000, 24'd32, 24'd16, 1'b0, 4'b0000};
    vecs[3] = '{1'b1, 2, 4'b0000, 24'd0,  24'd0,  1'b1, 4'b0000};
    vecs[4] = '{1'b0, 1, 4'b0110, 24'd8,  24'd4,  1'b0, 4'b0110};
    vecs[5] = '{1'b0, 2, 4'b0101, 24'd32, 24'd16, 1'b0, 4'b0101};
    vecs[6] = '{1'b0, 0, 4'b0000, 24'd2,  24'd1,  1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_a");
    cur_sel = 1'b1; #1;
    check_zero("reset_b");
    cur_sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_job(vecs[i], 1'b0);

    // A start while busy must neither restart nor queue a second job.
    run_job(vecs[1], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_job", busy_m, 0);

    // Abort in the period phase.
    cur_sel = 1'b0; mode = 2; init_drv = 4'b0000; start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    found = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      found = busy_m && start_s1_m && !start_s0_m;
    end
    check("reach_period", found, 1);
    repeat (3) begin
      @(posedge clk); #1;
      done_seen |= done_m;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_mid");
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      done_seen |= done_m;
    end
    check("no_done_on_abort", done_seen, 0);

    run_job(vecs[0], 1'b0);

    check("no_strobe_overlap", viol, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Sequencer for the GNR node array; each node holds a tortoise copy (s0) and a hare copy (s1).
- Per job it loads an initial state vector and pulses node steps so that s1 advances every step and s0 advances every second step. It detects the s0/s1 meet, then measures the attractor period.
- Reports meet step count, period, attractor state, and a timeout flag to the host-side job interface.

Parameters:
- N, 188, number of network nodes (state vector width).
- CNT_W, 32, width of step/period counters.
- MAX_STEPS, 2**20, step limit per phase before timeout; must be below 2**CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request pulse; sampled only when busy=0
- init_in  in  N  initial state vector, captured with start
- s0_vec  in  N  concatenated galphas_*_s0 outputs of all nodes
- s1_vec  in  N  concatenated galphas_*_s1 outputs of all nodes
- reset_nos  out  1  one-cycle node load strobe
- init_state  out  N  per-node init value, bit i to node i
- start_s0  out  1  tortoise step enable
- start_s1  out  1  hare step enable
- busy  out  1  job in progress
- done  out  1  one-cycle result strobe
- timeout  out  1  job ended on MAX_STEPS
- meet_steps  out  CNT_W  steps at s0==s1 meet
- period  out  CNT_W  attractor length
- attractor  out  N  s0_vec at period detection

Behaviour:
- Reset (rst=1): state IDLE; all outputs 0; counters 0.
- Reset mid-job: abort immediately to IDLE, no done pulse.
- IDLE:
  - busy=0.
  - start=1 captures init_in into init_state and clears counters and result registers.
  - Next state LOAD.
- LOAD (1 cycle):
  - reset_nos=1, busy=1; nodes load init_state and set their internal pass=1.
  - Next state RUN with steps=0.
- RUN:
  - start_s0 and start_s1 are combinational, both equal to ~hit.
  - steps increments every cycle in which the pulses are asserted.
  - Vectors sampled in a cycle reflect the current steps count: s1=f^steps(init), s0=f^ceil(steps/2)(init).
  - hit = (s0_vec==s1_vec) && steps>=2; steps=1 is a trivial equality and is ignored.
  - On hit: meet_steps<=steps, p=0, go to PERIOD. The hit cycle issues no pulse.
  - If steps==MAX_STEPS and no hit: timeout<=1, go to DONE.
- PERIOD:
  - start_s0=0, so s0 is frozen.
  - start_s1 = ~(p>=1 && s0_vec==s1_vec); p increments per s1 pulse.
  - On match with p>=1: period<=p, attractor<=s0_vec, go to DONE.
  - If p==MAX_STEPS: timeout<=1, go to DONE.
- DONE (1 cycle):
  - done=1, busy=1; next state IDLE.
  - Result registers hold until the next accepted start.
- start while busy=1 is ignored; no queueing.
- reset_nos, start_s0 and start_s1 are never asserted together.
- Counters saturate at MAX_STEPS; the timeout checks prevent wrap.
- Pure cycle of length L with no transient meets at steps=2L.

Decomposition:
- Package gnr_ctrl_pkg:
  - state enum IDLE/LOAD/RUN/PERIOD/DONE.
  - default N and CNT_W constants.
  - MAX_STEPS default.
- Sub-module gnr_vec_cmp: combinational N-bit equality of s0_vec/s1_vec with a parameterised reduction tree, instantiated once.
- FSM and counters stay in gnr_attractor_ctrl.

Test Plan:
- Bench setup: N=4 behavioural node model using the same pass/step semantics.
- Identity network f(x)=x, init=4'b1010:
  - reset_nos high exactly 1 cycle after start.
  - meet_steps=2, period=1, attractor=1010, timeout=0, done 1 cycle.
- Rotate-left network, init=0001: meet_steps=8, period=4, attractor is a rotation of 0001.
- Counter network x+1 mod 16, init=0: meet_steps=32, period=16.
- Counter network, MAX_STEPS=20: timeout=1 at steps=20, done pulses, period=0, busy drops the cycle after done.
- Protocol and reset:
  - start pulsed during RUN is ignored, and results match the first job.
  - rst asserted in PERIOD gives all outputs 0 the next cycle, with no done.
  - A fresh start then completes normally.
